// File: rtl/io_controller_if.sv
// io_controller_if: core M-stage I/O access, retire strobe and UART byte streams.
interface io_controller_if;
  logic        iowea;
  logic        io_re;
  logic [7:0]  io_addr;
  logic [31:0] io_wdata;
  logic        inst_retired;
  logic [31:0] io_rdata;
  logic [7:0]  uart_tx_data_in;
  logic        uart_tx_data_in_valid;
  logic        uart_tx_data_in_ready;
  logic [7:0]  uart_rx_data_out;
  logic        uart_rx_data_out_valid;
  logic        uart_rx_data_out_ready;
  modport master (
    output iowea, io_re, io_addr, io_wdata, inst_retired,
           uart_tx_data_in_ready, uart_rx_data_out, uart_rx_data_out_valid,
    input  io_rdata, uart_tx_data_in, uart_tx_data_in_valid, uart_rx_data_out_ready
  );
  modport slave (
    input  iowea, io_re, io_addr, io_wdata, inst_retired,
           uart_tx_data_in_ready, uart_rx_data_out, uart_rx_data_out_valid,
    output io_rdata, uart_tx_data_in, uart_tx_data_in_valid, uart_rx_data_out_ready
  );
endinterface

// File: rtl/io_controller.sv
// io_controller: memory-mapped I/O slave with UART TX FIFO, RX holding register and perf counters.
module io_controller #(
  parameter int TX_DEPTH = 4,
  parameter int PTR_W = 2
) (
  input logic clk,
  input logic rst,
  io_controller_if.slave bus
);
  localparam logic [PTR_W:0] depth = (PTR_W+1)'(TX_DEPTH);
  logic [7:0] mem [TX_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0] count;
  logic [7:0] off, rx_buf;
  logic [31:0] cyc_cnt, inst_cnt, rd;
  logic full, empty, push, pop, ovf_set, ovf_clr, rx_cap, rx_pop, cnt_clr;
  logic rx_full, overflow, unused;
  assign off = {bus.io_addr[7:2], 2'b00};
  assign unused = ^{bus.io_addr[1:0], bus.io_wdata[31:8]};
  assign full = count == depth;
  assign empty = count == '0;
  // full is judged before any same-cycle pop, so a push while full is always dropped
  assign push = bus.iowea && off == 8'h08 && !full;
  assign ovf_set = bus.iowea && off == 8'h08 && full;
  assign ovf_clr = bus.iowea && off == 8'h00;
  assign pop = !empty && bus.uart_tx_data_in_ready;
  assign rx_cap = bus.uart_rx_data_out_valid && !rx_full;
  assign rx_pop = bus.io_re && off == 8'h04;
  assign cnt_clr = bus.iowea && off == 8'h18;
  assign bus.uart_tx_data_in = mem[rd_ptr];
  assign bus.uart_tx_data_in_valid = !empty;
  assign bus.uart_rx_data_out_ready = !rx_full;
  always_comb begin
    rd = off == 8'h00 ? {29'b0, overflow, rx_full, !full} :
         off == 8'h04 ? {24'b0, rx_buf} :
         off == 8'h10 ? cyc_cnt :
         off == 8'h14 ? inst_cnt : 32'b0;
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.io_wdata[7:0];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
      rx_full <= 1'b0;
      rx_buf <= 8'b0;
      cyc_cnt <= 32'b0;
      inst_cnt <= 32'b0;
      bus.io_rdata <= 32'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
      overflow <= ovf_set | (overflow & !ovf_clr);
      if (rx_cap) rx_buf <= bus.uart_rx_data_out;
      rx_full <= rx_cap ? 1'b1 : rx_pop ? 1'b0 : rx_full;
      cyc_cnt <= cnt_clr ? 32'b0 : cyc_cnt + 32'd1;
      inst_cnt <= cnt_clr ? 32'b0 : inst_cnt + 32'(bus.inst_retired);
      if (bus.io_re) bus.io_rdata <= rd;
    end
  end
endmodule

// File: tb/tb_io_controller.sv
// tb_io_controller: directed scenario tests for io_controller with hand-computed expectations.
module tb_io_controller;
  logic clk = 1'b0;
  logic rst;
  int pass_cnt = 0;
  int total = 0;
  always #5 clk = ~clk;
  io_controller_if bus();
  io_controller #(.TX_DEPTH(4), .PTR_W(2)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [7:0] a);
    bus.io_re = 1'b1;
    bus.io_addr = a;
    tick();
    bus.io_re = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d);
    bus.iowea = 1'b1;
    bus.io_addr = a;
    bus.io_wdata = d;
    tick();
    bus.iowea = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.iowea = 1'b0;
    bus.io_re = 1'b0;
    bus.io_addr = 8'h00;
    bus.io_wdata = 32'h0;
    bus.inst_retired = 1'b0;
    bus.uart_tx_data_in_ready = 1'b0;
    bus.uart_rx_data_out = 8'h00;
    bus.uart_rx_data_out_valid = 1'b0;
    tick();
    tick();
    total++; if (bus.io_rdata !== 32'h0) $display("FAIL rst_rdata: got %0h exp 0", bus.io_rdata); else pass_cnt++;
    total++; if (bus.uart_tx_data_in_valid !== 1'b0) $display("FAIL rst_tx_valid: got %b exp 0", bus.uart_tx_data_in_valid); else pass_cnt++;
    total++; if (bus.uart_rx_data_out_ready !== 1'b1) $display("FAIL rst_rx_ready: got %b exp 1", bus.uart_rx_data_out_ready); else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_idle();
    repeat (10) tick();
    do_read(8'h10);
    total++; if (bus.io_rdata !== 32'd10) $display("FAIL idle_cycles: got %0d exp 10", bus.io_rdata); else pass_cnt++;
    do_read(8'h00);
    total++; if (bus.io_rdata !== 32'h1) $display("FAIL idle_status: got %0h exp 1", bus.io_rdata); else pass_cnt++;
    do_read(8'h20);
    total++; if (bus.io_rdata !== 32'h0) $display("FAIL unmapped_read: got %0h exp 0", bus.io_rdata); else pass_cnt++;
  endtask

  task automatic test_tx_overflow();
    for (int i = 0; i < 4; i++) do_write(8'h08, 32'hAB00_0041 + i);
    do_read(8'h00);
    total++; if (bus.io_rdata !== 32'h0) $display("FAIL tx_full_status: got %0h exp 0", bus.io_rdata); else pass_cnt++;
    do_write(8'h08, 32'h45);
    do_read(8'h00);
    total++; if (bus.io_rdata !== 32'h4) $display("FAIL tx_overflow_status: got %0h exp 4", bus.io_rdata); else pass_cnt++;
    bus.uart_tx_data_in_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++; if (bus.uart_tx_data_in_valid !== 1'b1 || bus.uart_tx_data_in !== 8'(8'h41 + i)) $display("FAIL tx_drain%0d: got v=%b d=%0h exp v=1 d=%0h", i, bus.uart_tx_data_in_valid, bus.uart_tx_data_in, 8'(8'h41 + i)); else pass_cnt++;
      tick();
    end
    total++; if (bus.uart_tx_data_in_valid !== 1'b0) $display("FAIL tx_empty: got %b exp 0", bus.uart_tx_data_in_valid); else pass_cnt++;
    bus.uart_tx_data_in_ready = 1'b0;
    do_write(8'h00, 32'h0);
    do_read(8'h00);
    total++; if (bus.io_rdata !== 32'h1) $display("FAIL ovf_clear: got %0h exp 1", bus.io_rdata); else pass_cnt++;
  endtask

  task automatic test_rx();
    bus.uart_rx_data_out = 8'h5A;
    bus.uart_rx_data_out_valid = 1'b1;
    tick();
    bus.uart_rx_data_out_valid = 1'b0;
    total++; if (bus.uart_rx_data_out_ready !== 1'b0) $display("FAIL rx_ready_low: got %b exp 0", bus.uart_rx_data_out_ready); else pass_cnt++;
    bus.uart_rx_data_out = 8'h77;
    bus.uart_rx_data_out_valid = 1'b1;
    tick();
    bus.uart_rx_data_out_valid = 1'b0;
    do_read(8'h00);
    total++; if (bus.io_rdata !== 32'h3) $display("FAIL rx_status: got %0h exp 3", bus.io_rdata); else pass_cnt++;
    do_read(8'h04);
    total++; if (bus.io_rdata !== 32'h5A) $display("FAIL rx_data: got %0h exp 5a", bus.io_rdata); else pass_cnt++;
    total++; if (bus.uart_rx_data_out_ready !== 1'b1) $display("FAIL rx_ready_back: got %b exp 1", bus.uart_rx_data_out_ready); else pass_cnt++;
    do_read(8'h04);
    total++; if (bus.io_rdata !== 32'h5A) $display("FAIL rx_stale: got %0h exp 5a", bus.io_rdata); else pass_cnt++;
    do_read(8'h00);
    total++; if (bus.io_rdata !== 32'h1) $display("FAIL rx_status_empty: got %0h exp 1", bus.io_rdata); else pass_cnt++;
  endtask

  task automatic test_counters();
    do_write(8'h18, 32'h0);
    bus.inst_retired = 1'b1;
    repeat (7) tick();
    bus.inst_retired = 1'b0;
    do_read(8'h14);
    total++; if (bus.io_rdata !== 32'd7) $display("FAIL inst_count: got %0d exp 7", bus.io_rdata); else pass_cnt++;
    bus.inst_retired = 1'b1;
    do_write(8'h18, 32'h0);
    bus.inst_retired = 1'b0;
    do_read(8'h14);
    total++; if (bus.io_rdata !== 32'd0) $display("FAIL inst_clear: got %0d exp 0", bus.io_rdata); else pass_cnt++;
    do_read(8'h10);
    total++; if (bus.io_rdata !== 32'd1) $display("FAIL cyc_restart: got %0d exp 1", bus.io_rdata); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    do_write(8'h08, 32'h11);
    do_write(8'h08, 32'h12);
    bus.uart_tx_data_in_ready = 1'b1;
    total++; if (bus.uart_tx_data_in !== 8'h11) $display("FAIL b2b_head: got %0h exp 11", bus.uart_tx_data_in); else pass_cnt++;
    do_write(8'h08, 32'h13);
    bus.uart_tx_data_in_ready = 1'b0;
    total++; if (bus.uart_tx_data_in !== 8'h12) $display("FAIL b2b_next: got %0h exp 12", bus.uart_tx_data_in); else pass_cnt++;
    do_write(8'h08, 32'h14);
    do_write(8'h08, 32'h15);
    do_read(8'h00);
    total++; if (bus.io_rdata !== 32'h0) $display("FAIL b2b_count: got %0h exp 0", bus.io_rdata); else pass_cnt++;
    bus.uart_tx_data_in_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++; if (bus.uart_tx_data_in_valid !== 1'b1 || bus.uart_tx_data_in !== 8'(8'h12 + i)) $display("FAIL b2b_order%0d: got v=%b d=%0h exp %0h", i, bus.uart_tx_data_in_valid, bus.uart_tx_data_in, 8'(8'h12 + i)); else pass_cnt++;
      tick();
    end
    bus.uart_tx_data_in_ready = 1'b0;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) do_write(8'h08, 32'(8'h20 + 4 * r + i));
      do_read(8'h00);
      total++; if (bus.io_rdata !== 32'h0) $display("FAIL wrap_full%0d: got %0h exp 0", r, bus.io_rdata); else pass_cnt++;
      bus.uart_tx_data_in_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
        total++; if (bus.uart_tx_data_in_valid !== 1'b1 || bus.uart_tx_data_in !== 8'(8'h20 + 4 * r + i)) $display("FAIL wrap%0d_%0d: got v=%b d=%0h exp %0h", r, i, bus.uart_tx_data_in_valid, bus.uart_tx_data_in, 8'(8'h20 + 4 * r + i)); else pass_cnt++;
        tick();
      end
      bus.uart_tx_data_in_ready = 1'b0;
      total++; if (bus.uart_tx_data_in_valid !== 1'b0) $display("FAIL wrap_empty%0d: got %b exp 0", r, bus.uart_tx_data_in_valid); else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) do_write(8'h08, 32'h60 + i);
    bus.uart_rx_data_out = 8'hC3;
    bus.uart_rx_data_out_valid = 1'b1;
    tick();
    bus.uart_rx_data_out_valid = 1'b0;
    do_read(8'h10);
    total++; if (bus.uart_tx_data_in_valid !== 1'b1 || bus.uart_rx_data_out_ready !== 1'b0 || bus.io_rdata === 32'h0) $display("FAIL pre_reset: got v=%b rdy=%b rd=%0h exp v=1 rdy=0 rd!=0", bus.uart_tx_data_in_valid, bus.uart_rx_data_out_ready, bus.io_rdata); else pass_cnt++;
    rst = 1'b1;
    #1;
    total++; if (bus.uart_tx_data_in_valid !== 1'b0) $display("FAIL async_tx_valid: got %b exp 0", bus.uart_tx_data_in_valid); else pass_cnt++;
    total++; if (bus.uart_rx_data_out_ready !== 1'b1) $display("FAIL async_rx_ready: got %b exp 1", bus.uart_rx_data_out_ready); else pass_cnt++;
    total++; if (bus.io_rdata !== 32'h0) $display("FAIL async_rdata: got %0h exp 0", bus.io_rdata); else pass_cnt++;
    tick();
    rst = 1'b0;
    tick();
    total++; if (bus.uart_tx_data_in_valid !== 1'b0) $display("FAIL post_reset_valid: got %b exp 0", bus.uart_tx_data_in_valid); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_idle();
    test_tx_overflow();
    test_rx();
    test_counters();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
